mux_pulse_seq: RTL and testbench
================================

MUX_PULSE_SEQ -- requirements
Module: mux_pulse_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the settle and pulse cycle counts.
REQ-002 SHALL have port clock, in, 1: sole clock; all state is updated on the rising edge.
REQ-003 SHALL have port reset_n, in, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, in, 1: single-cycle request to begin a sequence.
REQ-005 SHALL have port abort, in, 1: terminates an active sequence.
REQ-006 SHALL have port scan_mode, in, 1: 0 = single triple; 1 = scan from first_ch to last_ch.
REQ-007 SHALL have ports first_ch and last_ch, in, 4 each: scan start and end index k.
REQ-008 SHALL have ports med_ofs and high_ofs, in, 4 each: offsets applied to k for the med and high addresses.
REQ-009 SHALL have ports settle_cnt and pulse_cnt, in, CNT_W each: settle and pulse lengths in cycles.
REQ-010 SHALL have ports low_adr, med_adr and high_adr, out, 4 each: mux addresses.
REQ-011 SHALL have port mux_en, out, 1: mux enable (pulse window).
REQ-012 SHALL have ports busy, done and err, out, 1 each: sequence status.

Function
REQ-013 SHALL capture all configuration inputs on the cycle start is accepted; later input changes have no effect until the next start.
REQ-014 SHALL use states IDLE, SETTLE, PULSE, GAP, DONE.
REQ-015 SHALL, in IDLE, accept start only when abort is low, setting k = first_ch and entering SETTLE on the next cycle.
REQ-016 SHALL drive low_adr = k, med_adr = (k+med_ofs) mod 16 and high_adr = (k+high_ofs) mod 16, all registered and updated on entry to SETTLE.
REQ-017 SHALL hold SETTLE for max(settle_cnt,1) cycles with mux_en=0, then enter PULSE.
REQ-018 SHALL hold PULSE for max(pulse_cnt,1) cycles with mux_en=1, then enter GAP.
REQ-019 SHALL hold GAP for exactly 1 cycle with mux_en=0.
REQ-020 SHALL, leaving GAP, enter DONE if scan_mode=0 or k==last_ch; otherwise set k = (k+1) mod 16 and enter SETTLE.
REQ-021 SHALL support wrap-around: first_ch=14, last_ch=1 visits k = 14, 15, 0, 1.
REQ-022 SHALL, in DONE, pulse done high for exactly 1 cycle and return to IDLE.
REQ-023 SHALL change address outputs only while mux_en=0.
REQ-024 SHALL assert busy in every state except IDLE.
REQ-025 SHALL ignore start while busy=1.
REQ-026 SHALL, on abort in any non-IDLE state, drive mux_en=0 on the next cycle and go to IDLE without asserting done.
REQ-027 SHALL, when abort and start are both high in IDLE, let abort win and not start a sequence.
REQ-028 SHALL hold the last addresses in IDLE.

Reset
REQ-029 SHALL, on reset_n low, immediately set state=IDLE, all addresses=0, mux_en=0, busy=0, done=0, err=0, and k=0.
REQ-030 SHALL, on reset mid-PULSE, drop mux_en asynchronously.
REQ-031 SHALL leave IDLE no earlier than the first clock edge after reset_n rises.

Configuration
REQ-032 SHALL, with MUX_PULSE_SEQ_CONFLICT_CHECK_EN defined, compare the three address registers in SETTLE.
REQ-033 SHALL, when any two addresses are equal, never enter PULSE; instead set err (sticky until the next accepted start) and go to IDLE without done.
REQ-034 SHALL, without MUX_PULSE_SEQ_CONFLICT_CHECK_EN, tie err to 0 and perform no comparison.

Structure
REQ-035 SHALL place the state enumeration typedef and the address width constant (4) in the shared package mux_pulse_seq_pkg.
REQ-036 SHALL implement the settle and pulse down-counter as the sub-module mux_seq_timer (load, count, expire).

Verification
REQ-037 SHALL cover: single mode, first_ch=3, med_ofs=1, high_ofs=2, settle=2, pulse=3 -> adr 3/4/5, mux_en high 3 cycles starting 2 cycles after SETTLE entry, done 1 cycle later than GAP.
REQ-038 SHALL cover: scan 14 to 1 -> four pulses with low_adr 14, 15, 0, 1; med/high wrap mod 16; one done pulse.
REQ-039 SHALL cover: settle_cnt=0, pulse_cnt=0 -> each phase lasts 1 cycle.
REQ-040 SHALL cover: abort in the 2nd PULSE cycle -> mux_en=0 next cycle, IDLE, done never asserted; restart succeeds.
REQ-041 SHALL cover, with the macro defined: med_ofs=high_ofs=5 -> no mux_en, err=1, busy=0; next valid start clears err.
REQ-042 SHALL cover: reset_n low mid-PULSE -> all outputs 0 without waiting for a clock edge; start during busy is ignored (no restart of k).

Source files
------------

// File: rtl/mux_pulse_seq_pkg.sv
// -----------------------------------------------------------------------------
// mux_pulse_seq_pkg
// Shared definitions for the mux pulse sequencer: sequencer state encoding,
// mux address width and the modulo-16 address adder.
// -----------------------------------------------------------------------------
package mux_pulse_seq_pkg;

   localparam int ADR_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_PULSE  = 3'd2,
      ST_GAP    = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   // Address arithmetic wraps naturally at the address width (mod 16).
   function automatic logic [ADR_W-1:0] adr_add(input logic [ADR_W-1:0] base,
                                                input logic [ADR_W-1:0] ofs);
      return base + ofs;
   endfunction

endpackage

// File: rtl/mux_seq_timer.sv
// -----------------------------------------------------------------------------
// mux_seq_timer
// Phase down-counter for the SETTLE and PULSE phases. A load of 0 is treated
// as 1 so every phase lasts at least one cycle.
//
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   load_i      load load_val_i (takes effect on the next cycle)
//   load_val_i  requested phase length in cycles
//   count_i     decrement while a timed phase is active
//   expire_o    high in the last cycle of the loaded phase
// -----------------------------------------------------------------------------
module mux_seq_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             count_i,
   output logic             expire_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = (load_val_i == '0) ? CNT_W'(1) : load_val_i;
      end else if (count_i && (cnt_q > CNT_W'(1))) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   // Counter holds the remaining cycles including the current one.
   assign expire_o = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/mux_pulse_seq.sv
// -----------------------------------------------------------------------------
// mux_pulse_seq
// Drives a low/med/high mux address triple through SETTLE -> PULSE -> GAP
// phases, either for a single channel index k or scanning k from first_ch to
// last_ch (with wrap-around at 16). mux_en is high only during PULSE, and the
// addresses change only on entry to SETTLE, so they are stable while enabled.
//
// Optional feature: define MUX_PULSE_SEQ_CONFLICT_CHECK_EN to compare the
// three addresses in SETTLE; a collision aborts the sequence and sets err
// (sticky until the next accepted start). Otherwise err is tied to 0.
//
// Ports:
//   clock, reset_n          clock, asynchronous active-low reset
//   start, abort            begin a sequence / terminate an active one
//   scan_mode               0 = single triple, 1 = scan first_ch..last_ch
//   first_ch, last_ch       scan start / end index
//   med_ofs, high_ofs       offsets added to k for med/high addresses
//   settle_cnt, pulse_cnt   phase lengths in cycles (0 treated as 1)
//   low_adr/med_adr/high_adr mux addresses
//   mux_en                  pulse window
//   busy, done, err         status
// -----------------------------------------------------------------------------
module mux_pulse_seq
   import mux_pulse_seq_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic             abort,
   input  logic             scan_mode,
   input  logic [3:0]       first_ch,
   input  logic [3:0]       last_ch,
   input  logic [3:0]       med_ofs,
   input  logic [3:0]       high_ofs,
   input  logic [CNT_W-1:0] settle_cnt,
   input  logic [CNT_W-1:0] pulse_cnt,
   output logic [3:0]       low_adr,
   output logic [3:0]       med_adr,
   output logic [3:0]       high_adr,
   output logic             mux_en,
   output logic             busy,
   output logic             done,
   output logic             err
);

   state_e           state_q, state_d;
   logic [ADR_W-1:0] k_q, k_d;
   logic [ADR_W-1:0] low_q, med_q, high_q;
   logic [ADR_W-1:0] low_d, med_d, high_d;

   // Configuration captured when start is accepted.
   logic             scan_q;
   logic [ADR_W-1:0] last_q, med_ofs_q, high_ofs_q;
   logic [CNT_W-1:0] settle_q, pulse_q;

   logic             start_acc;
   logic             adr_load;
   logic             tmr_load, tmr_expire, tmr_count;
   logic [CNT_W-1:0] tmr_val;
   logic             conflict;
   logic [ADR_W-1:0] mofs_sel, hofs_sel;

`ifdef MUX_PULSE_SEQ_CONFLICT_CHECK_EN
   assign conflict = (low_q == med_q) || (low_q == high_q) || (med_q == high_q);
`else
   assign conflict = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      start_acc = 1'b0;
      tmr_load  = 1'b0;
      tmr_val   = settle_q;
      case (state_q)
         ST_IDLE: begin
            // abort has priority over start
            if (start && !abort) begin
               start_acc = 1'b1;
               state_d   = ST_SETTLE;
               k_d       = first_ch;
               tmr_load  = 1'b1;
               tmr_val   = settle_cnt;
            end
         end
         ST_SETTLE: begin
            if (abort || conflict) begin
               state_d = ST_IDLE;
            end else if (tmr_expire) begin
               state_d  = ST_PULSE;
               tmr_load = 1'b1;
               tmr_val  = pulse_q;
            end
         end
         ST_PULSE: begin
            if (abort)           state_d = ST_IDLE;
            else if (tmr_expire) state_d = ST_GAP;
         end
         ST_GAP: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (!scan_q || (k_q == last_q)) begin
               state_d = ST_DONE;
            end else begin
               state_d  = ST_SETTLE;
               k_d      = adr_add(k_q, ADR_W'(1));
               tmr_load = 1'b1;
               tmr_val  = settle_q;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Addresses only move on entry to SETTLE; at start the offsets come
   // straight from the inputs because the capture registers are not yet loaded.
   assign adr_load = (state_d == ST_SETTLE) && (state_q != ST_SETTLE);
   assign mofs_sel = start_acc ? med_ofs  : med_ofs_q;
   assign hofs_sel = start_acc ? high_ofs : high_ofs_q;

   always_comb begin
      low_d  = low_q;
      med_d  = med_q;
      high_d = high_q;
      if (adr_load) begin
         low_d  = k_d;
         med_d  = adr_add(k_d, mofs_sel);
         high_d = adr_add(k_d, hofs_sel);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         low_q   <= '0;
         med_q   <= '0;
         high_q  <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         low_q   <= low_d;
         med_q   <= med_d;
         high_q  <= high_d;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         scan_q     <= 1'b0;
         last_q     <= '0;
         med_ofs_q  <= '0;
         high_ofs_q <= '0;
         settle_q   <= '0;
         pulse_q    <= '0;
      end else if (start_acc) begin
         scan_q     <= scan_mode;
         last_q     <= last_ch;
         med_ofs_q  <= med_ofs;
         high_ofs_q <= high_ofs;
         settle_q   <= settle_cnt;
         pulse_q    <= pulse_cnt;
      end
   end

`ifdef MUX_PULSE_SEQ_CONFLICT_CHECK_EN
   logic err_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         err_q <= 1'b0;
      end else if (start_acc) begin
         err_q <= 1'b0;
      end else if ((state_q == ST_SETTLE) && !abort && conflict) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign tmr_count = (state_q == ST_SETTLE) || (state_q == ST_PULSE);

   mux_seq_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk_i      (clock),
      .rst_ni     (reset_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .count_i    (tmr_count),
      .expire_o   (tmr_expire)
   );

   // Status decoded from the state register so reset clears them at once.
   assign mux_en   = (state_q == ST_PULSE);
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);
   assign low_adr  = low_q;
   assign med_adr  = med_q;
   assign high_adr = high_q;

endmodule

// File: tb/tb_mux_pulse_seq.sv
// -----------------------------------------------------------------------------
// tb_mux_pulse_seq
// Self-checking bench: each sequence is expanded into the expected per-cycle
// output trace (phase lengths, visited channel list) and compared cycle by
// cycle. Compile with MUX_PULSE_SEQ_CONFLICT_CHECK_EN to include the address
// collision cases.
// -----------------------------------------------------------------------------
module tb_mux_pulse_seq;

   localparam int CNT_W = 8;

`ifdef MUX_PULSE_SEQ_CONFLICT_CHECK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic             scan_mode = 1'b0;
   logic [3:0]       first_ch = '0, last_ch = '0, med_ofs = '0, high_ofs = '0;
   logic [CNT_W-1:0] settle_cnt = '0, pulse_cnt = '0;
   logic [3:0]       low_adr, med_adr, high_adr;
   logic             mux_en, busy, done, err;

   mux_pulse_seq #(.CNT_W(CNT_W)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .start      (start),
      .abort      (abort),
      .scan_mode  (scan_mode),
      .first_ch   (first_ch),
      .last_ch    (last_ch),
      .med_ofs    (med_ofs),
      .high_ofs   (high_ofs),
      .settle_cnt (settle_cnt),
      .pulse_cnt  (pulse_cnt),
      .low_adr    (low_adr),
      .med_adr    (med_adr),
      .high_adr   (high_adr),
      .mux_en     (mux_en),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_fail = 0;

   logic [15:0] exp_q[$];
   logic [3:0]  m_low = '0, m_med = '0, m_high = '0;
   logic        m_err = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] pk(input logic [3:0] l, input logic [3:0] m,
                                      input logic [3:0] h, input logic en,
                                      input logic bsy, input logic dn, input logic er);
      return {l, m, h, en, bsy, dn, er};
   endfunction

   function automatic logic [15:0] obs();
      return {low_adr, med_adr, high_adr, mux_en, busy, done, err};
   endfunction

   // Expected trace of a sequence: per visited k, max(s,1) settle cycles,
   // max(p,1) pulse cycles, one gap; then one done cycle.
   task automatic build(input logic scan, input logic [3:0] first, input logic [3:0] last,
                        input logic [3:0] mo, input logic [3:0] ho,
                        input int s, input int p);
      logic [3:0] k, l, m, h;
      int ns, np;
      exp_q.delete();
      ns = (s == 0) ? 1 : s;
      np = (p == 0) ? 1 : p;
      k  = first;
      if (CHK_EN && ((mo == 4'd0) || (ho == 4'd0) || (mo == ho))) begin
         m = k + mo;
         h = k + ho;
         exp_q.push_back(pk(k, m, h, 1'b0, 1'b1, 1'b0, 1'b0));
         m_err = 1'b1;
         return;
      end
      m_err = 1'b0;
      forever begin
         l = k;
         m = k + mo;
         h = k + ho;
         repeat (ns) exp_q.push_back(pk(l, m, h, 1'b0, 1'b1, 1'b0, 1'b0));
         repeat (np) exp_q.push_back(pk(l, m, h, 1'b1, 1'b1, 1'b0, 1'b0));
         exp_q.push_back(pk(l, m, h, 1'b0, 1'b1, 1'b0, 1'b0));
         if (!scan || (k == last)) break;
         k = k + 4'd1;
      end
      exp_q.push_back(pk(l, m, h, 1'b0, 1'b1, 1'b1, 1'b0));
   endtask

   // Entered just after a rising edge in IDLE; leaves just after a rising edge.
   task automatic run(input string tag, input logic scan, input logic [3:0] first,
                      input logic [3:0] last, input logic [3:0] mo, input logic [3:0] ho,
                      input int s, input int p, input int abort_at, input bit noise);
      build(scan, first, last, mo, ho, s, p);
      if (abort_at >= 0) begin
         while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
      end
      m_low  = exp_q[exp_q.size()-1][15:12];
      m_med  = exp_q[exp_q.size()-1][11:8];
      m_high = exp_q[exp_q.size()-1][7:4];

      start      = 1'b1;
      scan_mode  = scan;
      first_ch   = first;
      last_ch    = last;
      med_ofs    = mo;
      high_ofs   = ho;
      settle_cnt = CNT_W'(s);
      pulse_cnt  = CNT_W'(p);
      @(posedge clock); #1;
      // Scramble configuration: captured values must be used.
      first_ch   = 4'($urandom);
      last_ch    = 4'($urandom);
      med_ofs    = 4'($urandom);
      high_ofs   = 4'($urandom);
      scan_mode  = 1'($urandom);
      settle_cnt = CNT_W'($urandom);
      pulse_cnt  = CNT_W'($urandom);
      for (int i = 0; i < exp_q.size(); i++) begin
         start = noise ? 1'($urandom) : 1'b0;
         abort = (i == abort_at);
         @(negedge clock);
         chk($sformatf("%s[%0d]", tag, i), 32'(obs()), 32'(exp_q[i]));
         @(posedge clock); #1;
      end
      start = 1'b0;
      abort = 1'b0;
      @(negedge clock);
      chk({tag, "_idle"}, 32'(obs()), 32'(pk(m_low, m_med, m_high, 1'b0, 1'b0, 1'b0, m_err)));
      @(posedge clock); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #2;
      chk("reset", 32'(obs()), 32'h0);
      #21 reset_n = 1'b1;
      @(posedge clock); #1;
      @(negedge clock);
      chk("post_reset_idle", 32'(obs()), 32'h0);
      @(posedge clock); #1;

      // Basic single triple
      run("single", 1'b0, 4'd3, 4'd0, 4'd1, 4'd2, 2, 3, -1, 1'b0);
      // Scan with wrap-around
      run("scan_wrap", 1'b1, 4'd14, 4'd1, 4'd3, 4'd9, 1, 2, -1, 1'b0);
      // Zero-length phases
      run("zero_len", 1'b1, 4'd5, 4'd6, 4'd2, 4'd4, 0, 0, -1, 1'b0);
      // Abort in the 2nd PULSE cycle, then restart
      run("abort", 1'b0, 4'd2, 4'd0, 4'd1, 4'd3, 2, 4, 3, 1'b0);
      run("restart", 1'b0, 4'd9, 4'd0, 4'd2, 4'd5, 1, 1, -1, 1'b0);

      // Start and abort together in IDLE: abort wins
      start = 1'b1;
      abort = 1'b1;
      first_ch = 4'd12;
      @(posedge clock); #1;
      start = 1'b0;
      abort = 1'b0;
      @(negedge clock);
      chk("start_abort", 32'(obs()), 32'(pk(m_low, m_med, m_high, 1'b0, 1'b0, 1'b0, m_err)));
      @(posedge clock); #1;

`ifdef MUX_PULSE_SEQ_CONFLICT_CHECK_EN
      run("conflict", 1'b0, 4'd4, 4'd0, 4'd5, 4'd5, 2, 3, -1, 1'b0);
      run("conflict_clear", 1'b0, 4'd4, 4'd0, 4'd1, 4'd2, 1, 2, -1, 1'b0);
`endif

      // Starts during busy are ignored (noise on start)
      run("busy_start", 1'b1, 4'd0, 4'd2, 4'd7, 4'd11, 2, 2, -1, 1'b1);

      // Reset mid-PULSE drops everything without a clock edge
      start = 1'b1; scan_mode = 1'b0; first_ch = 4'd7;
      med_ofs = 4'd3; high_ofs = 4'd9; settle_cnt = 8'd2; pulse_cnt = 8'd5;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clock); #1;
      end
      chk("rst_pre_pulse", 32'(mux_en), 32'h1);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_async", 32'(obs()), 32'h0);
      @(posedge clock); #3;
      reset_n = 1'b1;
      @(posedge clock); #1;
      @(negedge clock);
      chk("rst_release_idle", 32'(obs()), 32'h0);
      @(posedge clock); #1;
      m_low = '0; m_med = '0; m_high = '0; m_err = 1'b0;
      run("after_reset", 1'b0, 4'd1, 4'd0, 4'd4, 4'd8, 1, 2, -1, 1'b0);

      // Randomized sequences
      for (int r = 0; r < 30; r++) begin
         run($sformatf("rnd%0d", r), 1'($urandom), 4'($urandom), 4'($urandom),
             4'($urandom), 4'($urandom), int'($urandom_range(0, 4)),
             int'($urandom_range(0, 4)), -1, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
